// File: rtl/dsp48a1_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp48a1_mac_seq
// Brief    : Drives one DSP48A1 slice as a signed dot-product MAC engine.
// Revision : 1.0
// ============================================================================
module dsp48a1_mac_seq #(
    parameter int CNT_W    = 10,
    parameter int PIPE_LAT = 3,
    parameter int OPM_DLY  = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p,
    output logic             busy,
    output logic [47:0]      result,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] c_OP_ZERO  = 8'b0000_0000;
    localparam logic [7:0] c_OP_FIRST = 8'b0000_0001;
    localparam logic [7:0] c_OP_HOLD  = 8'b0000_1000;
    localparam logic [7:0] c_OP_ACC   = 8'b0000_1001;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              first_q, first_d;
    logic [PIPE_LAT:0] tag_q, tag_d;
    logic [7:0]        op_pipe_q [0:OPM_DLY];
    logic [7:0]        op_pipe_d [0:OPM_DLY];
    logic              s_ready_q, s_ready_d;
    logic [17:0]       dsp_a_q, dsp_a_d;
    logic [17:0]       dsp_b_q, dsp_b_d;
    logic              dsp_rst_q;
    logic              busy_q, busy_d;
    logic [47:0]       result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              xfer;
    logic              last_xfer;
    logic [7:0]        slot_op;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        result_d    = result_q;

        // s_ready_q is only ever high while in RUN
        xfer      = s_valid & s_ready_q;
        last_xfer = xfer && (remaining_q == CNT_W'(1));
        dsp_a_d   = xfer ? s_a : 18'd0;
        dsp_b_d   = xfer ? s_b : 18'd0;

        slot_op = c_OP_ZERO;
        if (state_q == S_RUN || state_q == S_DRAIN) begin
            if (xfer) slot_op = first_q ? c_OP_FIRST : c_OP_ACC;
            else      slot_op = first_q ? c_OP_ZERO  : c_OP_HOLD;
        end

        op_pipe_d[0] = slot_op;
        for (int i = 1; i <= OPM_DLY; i++) begin
            op_pipe_d[i] = op_pipe_q[i-1];
        end

        // The "last" tag surfaces at tag_q[PIPE_LAT] in the cycle P holds the final sum
        tag_d = {tag_q[PIPE_LAT-1:0], last_xfer};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len;
                    if (len != '0) begin
                        state_d     = S_RUN;
                        remaining_d = len;
                        first_d     = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        result_d = 48'd0;
                    end
                end
            end
            S_RUN: begin
                if (xfer) begin
                    first_d     = 1'b0;
                    remaining_d = remaining_q - CNT_W'(1);
                    if (last_xfer) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tag_q[PIPE_LAT]) begin
                    state_d  = S_DONE;
                    result_d = dsp_p;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        s_ready_d      = (state_d == S_RUN);
        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        dsp_rst_q <= RST;
        if (RST) begin
            state_q        <= S_IDLE;
            len_q          <= '0;
            remaining_q    <= '0;
            first_q        <= 1'b0;
            tag_q          <= '0;
            for (int i = 0; i <= OPM_DLY; i++) op_pipe_q[i] <= 8'd0;
            s_ready_q      <= 1'b0;
            dsp_a_q        <= 18'd0;
            dsp_b_q        <= 18'd0;
            busy_q         <= 1'b0;
            result_q       <= 48'd0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            remaining_q    <= remaining_d;
            first_q        <= first_d;
            tag_q          <= tag_d;
            for (int i = 0; i <= OPM_DLY; i++) op_pipe_q[i] <= op_pipe_d[i];
            s_ready_q      <= s_ready_d;
            dsp_a_q        <= dsp_a_d;
            dsp_b_q        <= dsp_b_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign dsp_a        = dsp_a_q;
    assign dsp_b        = dsp_b_q;
    assign dsp_opmode   = op_pipe_q[OPM_DLY];
    assign dsp_rst      = dsp_rst_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp48a1_mac_seq
// Brief    : Scoreboard bench for dsp48a1_mac_seq with a DSP48A1 slice model.
// Revision : 1.0
// ============================================================================
module tb_dsp48a1_mac_seq;

    localparam int CNT_W    = 10;
    localparam int PIPE_LAT = 3;
    localparam int OPM_DLY  = 1;
    localparam int LAT      = PIPE_LAT + 2;
    localparam int TRMAX    = 16384;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             s_valid = 1'b0;
    logic [17:0]      s_a = '0;
    logic [17:0]      s_b = '0;
    logic             s_ready;
    logic [17:0]      dsp_a, dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_rst;
    logic [47:0]      dsp_p;
    logic             busy;
    logic [47:0]      result;
    logic             result_valid;

    dsp48a1_mac_seq #(.CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT), .OPM_DLY(OPM_DLY)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p), .busy(busy), .result(result), .result_valid(result_valid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // DSP48A1 slice: A1REG/B1REG -> MREG -> PREG, registered OPMODE
    logic signed [17:0] a1, b1;
    logic signed [35:0] m;
    logic [7:0]         opm;
    logic [47:0]        p;
    always @(posedge CLK) begin
        if (dsp_rst) begin
            a1 <= '0; b1 <= '0; m <= '0; opm <= '0; p <= '0;
        end else begin
            a1  <= dsp_a;
            b1  <= dsp_b;
            m   <= a1 * b1;
            opm <= dsp_opmode;
            p   <= ((opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0)
                 + ((opm[3:2] == 2'b10) ? p : 48'd0);
        end
    end
    assign dsp_p = p;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [47:0] val;
        int          due;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    logic [7:0]  op_tr [0:TRMAX-1];
    logic        sr_tr [0:TRMAX-1];
    logic [47:0] last_res = '0;

    // Monitor: pops the scoreboard whenever the DUT strobes a result
    always @(negedge CLK) begin
        if (cyc < TRMAX) begin
            op_tr[cyc] = dsp_opmode;
            sr_tr[cyc] = s_ready;
        end
        if (!RST) begin
            chk("opmode_upper_bits", {60'd0, dsp_opmode[7:4]}, 64'd0);
            if (result_valid) begin
                last_res = result;
                if (sbq.size() == 0) begin
                    chk("unexpected_result_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result", {16'd0, result}, {16'd0, mon_e.val});
                    chk("result_time", 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    // Reference model state: plain signed sum of products modulo 2^48
    longint      acc;
    int          xq[$];
    int          c0;
    logic [17:0] ja[$];
    logic [17:0] jb[$];
    int          jbub[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = CNT_W'(n);
        @(negedge CLK);
        c0 = cyc;
        chk("start_sampled_idle", {63'd0, busy}, 64'd0);
        if (n == 0) sbq.push_back('{val: 48'd0, due: cyc + 1});
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, input int pre_bub, input bit last);
        int w;
        w = 0;
        s_valid = 1'b0;
        repeat (pre_bub) tick();
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        forever begin
            @(negedge CLK);
            if (s_ready) break;
            w++;
            if (w > 50) begin
                chk("s_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        if (s_ready) begin
            xq.push_back(cyc);
            acc = acc + longint'($signed(a)) * longint'($signed(b));
            if (last) sbq.push_back('{val: acc[47:0], due: cyc + LAT});
        end
        tick();
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge CLK);
        while (busy && w < 2000) begin
            @(negedge CLK);
            w++;
        end
        if (busy) chk("busy_timeout", 64'd1, 64'd0);
        tick();
    endtask

    task automatic run_job();
        acc = 0;
        xq.delete();
        do_start(ja.size());
        for (int i = 0; i < ja.size(); i++)
            send(ja[i], jb[i], jbub[i], i == ja.size() - 1);
        wait_idle();
    endtask

    task automatic load_basic(input int b0, input int b2);
        ja = '{18'd1, 18'd3, 18'd5, 18'd7};
        jb = '{18'd2, 18'd4, 18'd6, 18'd8};
        jbub = '{b0, 0, b2, 0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_dsp_a", {46'd0, dsp_a}, 64'd0);
        chk("rst_dsp_b", {46'd0, dsp_b}, 64'd0);
        chk("rst_opmode", {56'd0, dsp_opmode}, 64'd0);
        chk("rst_dsp_rst", {63'd0, dsp_rst}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", {16'd0, result}, 64'd0);
        chk("rst_result_valid", {63'd0, result_valid}, 64'd0);
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("dsp_rst_lags_rst", {63'd0, dsp_rst}, 64'd1);
        @(negedge CLK);
        chk("dsp_rst_released", {63'd0, dsp_rst}, 64'd0);
        tick();

        // Basic sum with opmode sequence
        load_basic(0, 0);
        run_job();
        chk("basic_result", {16'd0, last_res}, 64'd100);
        chk("basic_back_to_back_xfers", 64'(xq[3] - xq[0]), 64'd3);
        for (int i = 0; i < 4; i++)
            chk("basic_slot_opmode", {56'd0, op_tr[xq[i] + 2]}, (i == 0) ? 64'h01 : 64'h09);
        chk("basic_hold_opmode", {56'd0, op_tr[xq[3] + 3]}, 64'h08);

        // Signed operands
        ja = '{-18'sd3, 18'd2}; jb = '{18'd5, 18'd7}; jbub = '{0, 0};
        run_job();
        chk("signed_minus_one", {16'd0, last_res}, {16'd0, 48'hFFFF_FFFF_FFFF});
        ja = '{18'h20000}; jb = '{18'h20000}; jbub = '{0};
        run_job();
        chk("signed_min_squared", {16'd0, last_res}, {16'd0, 48'h0004_0000_0000});

        // Bubbles: one leading, two after pair 2
        load_basic(1, 2);
        run_job();
        chk("bubble_result", {16'd0, last_res}, 64'd100);
        chk("bubble_leading_opmode", {56'd0, op_tr[c0 + 3]}, 64'h00);
        chk("bubble_mid_opmode_1", {56'd0, op_tr[xq[1] + 3]}, 64'h08);
        chk("bubble_mid_opmode_2", {56'd0, op_tr[xq[1] + 4]}, 64'h08);
        chk("bubble_first_opmode", {56'd0, op_tr[xq[0] + 2]}, 64'h01);

        // Zero length
        ja.delete(); jb.delete(); jbub.delete();
        run_job();
        chk("zero_len_result", {16'd0, last_res}, 64'd0);
        for (int c = 0; c < 5; c++) begin
            chk("zero_len_opmode", {56'd0, op_tr[c0 + c]}, 64'h00);
            chk("zero_len_s_ready", {63'd0, sr_tr[c0 + c]}, 64'd0);
        end

        // Reset mid-job: no result for the aborted job
        acc = 0;
        xq.delete();
        do_start(8);
        for (int i = 0; i < 3; i++) send(18'(i + 11), 18'(i + 3), 0, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_dsp_rst", {63'd0, dsp_rst}, 64'd1);
        chk("midrst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("midrst_result_valid", {63'd0, result_valid}, 64'd0);
        repeat (8) tick();
        load_basic(0, 0);
        run_job();
        chk("after_rst_result", {16'd0, last_res}, 64'd100);

        // start in RUN and in DONE is ignored; start in following IDLE is taken
        acc = 0;
        xq.delete();
        do_start(2);
        start = 1'b1;
        len   = CNT_W'(5);
        send(18'd4, 18'd5, 0, 1'b0);
        start = 1'b0;
        send(18'd6, 18'd7, 0, 1'b1);
        while (cyc < xq[1] + LAT) tick();
        start = 1'b1;
        len   = CNT_W'(3);
        tick();
        chk("b2b_first_result", {16'd0, last_res}, 64'd62);
        acc = 0;
        xq.delete();
        do_start(1);
        send(18'd9, 18'd9, 0, 1'b1);
        wait_idle();
        chk("b2b_second_result", {16'd0, last_res}, 64'd81);

        // Randomised jobs
        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(1, 12);
            ja.delete(); jb.delete(); jbub.delete();
            for (int i = 0; i < n; i++) begin
                ja.push_back(18'($urandom));
                jb.push_back(18'($urandom));
                jbub.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            run_job();
        end

        // Maximum length
        ja.delete(); jb.delete(); jbub.delete();
        for (int i = 0; i < 1023; i++) begin
            ja.push_back(18'($urandom));
            jb.push_back(18'($urandom));
            jbub.push_back(0);
        end
        run_job();

        repeat (5) tick();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp48a1_mac_seq.md
Name: dsp48a1_mac_seq

Overview:
- Sequencer that runs one DSP48A1 slice as a signed multiply-accumulate engine. It computes the dot product of N operand pairs: sum(A_i*B_i).
- Accepts a job (length) plus a valid/ready stream of 18-bit operand pairs. Drives the slice's A, B and OPMODE inputs, tracks the slice pipeline and returns the 48-bit P result with a one-cycle strobe.
- Sits between stream-producing logic and the DSP48A1 instance, which is configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT".

Parameters:
- CNT_W, 10, width of job length; maximum length is 2^CNT_W-1.
- PIPE_LAT, 3, cycles from slice A/B input to P output (A1REG -> MREG -> PREG).
- OPM_DLY, 1, cycles dsp_opmode lags dsp_a/dsp_b so that the registered OPMODE reaches the post-adder with its element.

Ports:
- CLK in 1: clock, rising edge.
- RST in 1: synchronous, active-high reset.
- start in 1: job request; sampled only in IDLE.
- len in CNT_W: number of operand pairs, sampled with start.
- s_valid in 1: operand pair valid.
- s_ready out 1: sequencer accepts a pair this cycle.
- s_a in 18: signed operand A.
- s_b in 18: signed operand B.
- dsp_a out 18: to DSP48A1 A.
- dsp_b out 18: to DSP48A1 B.
- dsp_opmode out 8: to DSP48A1 OPMODE.
- dsp_rst out 1: to all DSP48A1 RST* inputs.
- dsp_p in 48: from DSP48A1 P.
- busy out 1: job in progress.
- result out 48: signed accumulated sum.
- result_valid out 1: one-cycle strobe, result is valid.

Behaviour:
- Reset values: s_ready=0, dsp_a=0, dsp_b=0, dsp_opmode=8'h00, dsp_rst=1, busy=0, result=0, result_valid=0. The state is IDLE, the counters are 0 and the tag pipe is cleared.
- dsp_rst is a registered copy of RST: it deasserts one cycle after RST falls. All DSP CE inputs are tied high at the top level.
- All outputs are registered.

States:
- IDLE:
  - start=1 with len!=0 goes to RUN: latch len, remaining=len, first=1.
  - start=1 with len=0 goes to DONE with result=0. No non-zero opmode is issued.
- RUN:
  - s_ready=1.
  - A transfer occurs when s_valid&s_ready.
  - When remaining reaches 0 after the last transfer, go to DRAIN. s_ready drops in the cycle after the last transfer.
- DRAIN:
  - s_ready=0.
  - Wait until the last-element tag exits the delay pipe, then go to DONE.
- DONE:
  - result <= dsp_p is captured on entry and result_valid=1 for exactly this cycle.
  - Next state is IDLE.
- busy=1 in RUN, DRAIN and DONE.

Issue slots (every cycle in RUN/DRAIN is one slot):
- Transfer in cycle t: dsp_a/dsp_b = s_a/s_b during cycle t+1.
- Slot opmode during cycle t+1+OPM_DLY:
  - 8'b0000_0001 (X=M, Z=0) for the first element.
  - 8'b0000_1001 (X=M, Z=P) otherwise.
- No transfer (bubble, s_valid=0 in RUN, or any DRAIN cycle): dsp_a=dsp_b=0.
  - Opmode is 8'b0000_1000 (X=0, Z=P), so P is held.
  - A bubble before the first element uses 8'h00.
- Opmode bits 4-7 are always 0: no pre-adder, no carry-in, no subtraction.

Result timing and arithmetic:
- For the last transfer at cycle t, the final sum is visible on dsp_p at cycle t+1+PIPE_LAT and result_valid is asserted at cycle t+2+PIPE_LAT. With the default parameters this is t+5.
- Latency is tracked with a 1-bit "last" tag shifted through a (1+OPM_DLY)- and PIPE_LAT-aligned delay line. Latency is not tracked by state-only counting.
- The sum is a signed 36-bit product, sign-extended and accumulated modulo 2^48. Overflow wraps silently.

Boundary conditions:
- start while busy: ignored. The len latch is unchanged.
- start in the same cycle as DONE: ignored, because start is sampled only in IDLE.
- s_valid outside RUN: ignored, no transfer.
- RST mid-job: next cycle all state and outputs return to reset values and dsp_rst=1. There is no result_valid for the aborted job. The next job after RST is released computes correctly.
- len = 2^CNT_W-1: completes normally with no counter wrap.

Test Plan:
- Basic sum: len=4, pairs (1,2),(3,4),(5,6),(7,8), s_valid held high -> s_ready high for 4 cycles, result=100, result_valid 5 cycles after the 4th transfer, opmode sequence 01,09,09,09 then 08.
- Signed: len=2, pairs (-3,5),(2,7) -> result=48'hFFFF_FFFF_FFFF (-1). Also (-131072,-131072) alone -> result=48'h0004_0000_0000.
- Bubbles: the basic-sum job with s_valid low for 2 cycles after pair 2 and 1 cycle before pair 1 -> result=100, opmode 00 for the leading bubble and 08 for the mid bubbles, result_valid 5 cycles after the last transfer.
- Zero length: start with len=0 -> result_valid the next cycle, result=0, s_ready never high, dsp_opmode stays 00.
- Reset mid-job: start len=8, assert RST after 3 transfers for 1 cycle -> busy=0, dsp_rst=1, no result_valid. Then run the basic-sum job -> result=100.
- Back-to-back: start asserted again in RUN and DONE cycles -> ignored. A start in the IDLE cycle after DONE with len=1 and pair (9,9) -> result=81, and the previous accumulation does not leak in.
